// File: rtl/add_sub_4bit_bcd_to_fnd.sv
// -----------------------------------------------------------------------------
// add_sub_4bit_bcd_to_fnd
//
// Purpose:
//   Adds or subtracts two 4-bit unsigned operands. The result is split into
//   decimal digits without any multi-cycle conversion. One selected digit is
//   shown on a 4-digit common-anode FND (seven-segment display). All outputs
//   are registered, so every output lags the sampled inputs by exactly one
//   cycle.
//
// Ports:
//   i_clk          in   1  system clock, rising edge active
//   i_reset        in   1  asynchronous active-high reset
//   i_digitSelect  in   2  index of the digit to drive (0..3)
//   i_en           in   1  active-low display enable (1 blanks the display)
//   i_mode         in   1  0 = add, 1 = subtract
//   i_a            in   4  unsigned operand A
//   i_b            in   4  unsigned operand B
//   o_digit        out  4  active-low one-hot digit common select
//   o_font         out  8  active-low segments {dp,g,f,e,d,c,b,a}
//   o_c            out  1  carry out of the 4-bit add/subtract
//
// Digit map:
//   digit0 = units, digit1 = tens (always shown, including a leading '0'),
//   digit2 = blank, digit3 = minus sign for a negative difference, else blank.
// -----------------------------------------------------------------------------
module add_sub_4bit_bcd_to_fnd (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_digitSelect,
  input  logic       i_en,
  input  logic       i_mode,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_digit,
  output logic [7:0] o_font,
  output logic       o_c
);

  localparam logic [7:0] FONT_BLANK = 8'hFF;
  localparam logic [7:0] FONT_MINUS = 8'hBF;
  localparam logic [3:0] DIGIT_OFF  = 4'b1111;

  // Maps a decimal digit to its active-low segment code. Any other code
  // renders blank.
  function automatic logic [7:0] bcd_to_font(input logic [3:0] bcd);
    logic [7:0] font;
    case (bcd)
      4'd0:    font = 8'hC0;
      4'd1:    font = 8'hF9;
      4'd2:    font = 8'hA4;
      4'd3:    font = 8'hB0;
      4'd4:    font = 8'h99;
      4'd5:    font = 8'h92;
      4'd6:    font = 8'h82;
      4'd7:    font = 8'hF8;
      4'd8:    font = 8'h80;
      4'd9:    font = 8'h90;
      default: font = FONT_BLANK;
    endcase
    return font;
  endfunction

  // Converts a digit index to its active-low one-hot common select.
  function automatic logic [3:0] sel_to_digit(input logic [1:0] sel);
    logic [3:0] digit;
    case (sel)
      2'd0:    digit = 4'b1110;
      2'd1:    digit = 4'b1101;
      2'd2:    digit = 4'b1011;
      2'd3:    digit = 4'b0111;
      default: digit = DIGIT_OFF;
    endcase
    return digit;
  endfunction

  // Splits a value in 0..31 into {tens[1:0], units[3:0]} using only
  // comparisons and one subtraction. The largest value reached is 30.
  function automatic logic [5:0] split_decimal(input logic [4:0] value);
    logic [1:0] tens;
    logic [4:0] rem;
    if (value >= 5'd30) begin
      tens = 2'd3;
      rem  = value - 5'd30;
    end else if (value >= 5'd20) begin
      tens = 2'd2;
      rem  = value - 5'd20;
    end else if (value >= 5'd10) begin
      tens = 2'd1;
      rem  = value - 5'd10;
    end else begin
      tens = 2'd0;
      rem  = value;
    end
    return {tens, rem[3:0]};
  endfunction

  logic [4:0] raw_sum_s;
  logic       carry_s;
  logic       negative_s;
  logic [4:0] display_value_s;
  logic [5:0] split_s;
  logic [3:0] units_s;
  logic [1:0] tens_s;
  logic [7:0] font_next_s;
  logic [3:0] digit_next_s;

  logic [3:0] digit_r;
  logic [7:0] font_r;
  logic       c_r;

  // Arithmetic core. Subtraction is a + ~b + 1, so the carry out is set
  // exactly when no borrow occurs (a >= b).
  always_comb begin
    raw_sum_s       = 5'd0;
    negative_s      = 1'b0;
    display_value_s = 5'd0;
    if (i_mode) begin
      raw_sum_s  = {1'b0, i_a} + {1'b0, ~i_b} + 5'd1;
      negative_s = (i_a < i_b);
      if (negative_s) begin
        display_value_s = {1'b0, i_b - i_a};
      end else begin
        display_value_s = {1'b0, i_a - i_b};
      end
    end else begin
      raw_sum_s       = {1'b0, i_a} + {1'b0, i_b};
      negative_s      = 1'b0;
      display_value_s = raw_sum_s;
    end
    carry_s = raw_sum_s[4];
  end

  // Decimal digit extraction.
  always_comb begin
    split_s = split_decimal(display_value_s);
    tens_s  = split_s[5:4];
    units_s = split_s[3:0];
  end

  // Picks the font and common for the selected digit. The disable input
  // blanks both the font and the common select.
  always_comb begin
    font_next_s  = FONT_BLANK;
    digit_next_s = DIGIT_OFF;
    if (i_en) begin
      font_next_s  = FONT_BLANK;
      digit_next_s = DIGIT_OFF;
    end else begin
      digit_next_s = sel_to_digit(i_digitSelect);
      case (i_digitSelect)
        2'd0:    font_next_s = bcd_to_font(units_s);
        2'd1:    font_next_s = bcd_to_font({2'b00, tens_s});
        2'd2:    font_next_s = FONT_BLANK;
        2'd3:    font_next_s = negative_s ? FONT_MINUS : FONT_BLANK;
        default: font_next_s = FONT_BLANK;
      endcase
    end
  end

  // Output registers. All outputs update together on one edge, so no
  // intermediate state can appear on the outputs. Reset forces them dark.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      digit_r <= DIGIT_OFF;
      font_r  <= FONT_BLANK;
      c_r     <= 1'b0;
    end else begin
      digit_r <= digit_next_s;
      font_r  <= font_next_s;
      c_r     <= carry_s;
    end
  end

  assign o_digit = digit_r;
  assign o_font  = font_r;
  assign o_c     = c_r;

endmodule

// File: tb/tb_add_sub_4bit_bcd_to_fnd.sv
module tb_add_sub_4bit_bcd_to_fnd;

  logic       i_clk;
  logic       i_reset;
  logic [1:0] i_digitSelect;
  logic       i_en;
  logic       i_mode;
  logic [3:0] i_a;
  logic [3:0] i_b;
  logic [3:0] o_digit;
  logic [7:0] o_font;
  logic       o_c;

  int total_cnt;
  int bad_cnt;

  add_sub_4bit_bcd_to_fnd dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_digitSelect (i_digitSelect),
    .i_en          (i_en),
    .i_mode        (i_mode),
    .i_a           (i_a),
    .i_b           (i_b),
    .o_digit       (o_digit),
    .o_font        (o_font),
    .o_c           (o_c)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [15:0] obs,
                           input logic [15:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one input vector and checks the registered result one edge later.
  task automatic run_vec(input string tag, input logic [3:0] a,
                         input logic [3:0] b, input logic mode,
                         input logic en, input logic [1:0] sel,
                         input logic [3:0] exp_digit,
                         input logic [7:0] exp_font, input logic exp_c);
    i_a           = a;
    i_b           = b;
    i_mode        = mode;
    i_en          = en;
    i_digitSelect = sel;
    @(posedge i_clk);
    #1;
    check_val({tag, "_digit"}, {12'd0, o_digit}, {12'd0, exp_digit});
    check_val({tag, "_font"},  {8'd0, o_font},   {8'd0, exp_font});
    check_val({tag, "_c"},     {15'd0, o_c},     {15'd0, exp_c});
  endtask

  initial begin
    total_cnt     = 0;
    bad_cnt       = 0;
    i_reset       = 1'b1;
    i_a           = 4'd3;
    i_b           = 4'd7;
    i_mode        = 1'b0;
    i_en          = 1'b0;
    i_digitSelect = 2'd0;
    #3;
    check_val("rst_digit", {12'd0, o_digit}, 16'h000F);
    check_val("rst_font",  {8'd0, o_font},   16'h00FF);
    check_val("rst_c",     {15'd0, o_c},     16'h0000);
    @(posedge i_clk);
    #1;
    check_val("rst_hold_font", {8'd0, o_font}, 16'h00FF);
    i_reset = 1'b0;

    // Add 3+7=10
    run_vec("add37_s0", 4'd3, 4'd7, 1'b0, 1'b0, 2'd0, 4'b1110, 8'hC0, 1'b0);
    run_vec("add37_s1", 4'd3, 4'd7, 1'b0, 1'b0, 2'd1, 4'b1101, 8'hF9, 1'b0);
    // Add 9+9=18
    run_vec("add99_s0", 4'd9, 4'd9, 1'b0, 1'b0, 2'd0, 4'b1110, 8'h80, 1'b1);
    run_vec("add99_s1", 4'd9, 4'd9, 1'b0, 1'b0, 2'd1, 4'b1101, 8'hF9, 1'b1);
    run_vec("add99_s2", 4'd9, 4'd9, 1'b0, 1'b0, 2'd2, 4'b1011, 8'hFF, 1'b1);
    run_vec("add99_s3", 4'd9, 4'd9, 1'b0, 1'b0, 2'd3, 4'b0111, 8'hFF, 1'b1);
    // Sub 8-2=6
    run_vec("sub82_s0", 4'd8, 4'd2, 1'b1, 1'b0, 2'd0, 4'b1110, 8'h82, 1'b1);
    run_vec("sub82_s1", 4'd8, 4'd2, 1'b1, 1'b0, 2'd1, 4'b1101, 8'hC0, 1'b1);
    run_vec("sub82_s3", 4'd8, 4'd2, 1'b1, 1'b0, 2'd3, 4'b0111, 8'hFF, 1'b1);
    // Sub 1-9=-8
    run_vec("sub19_s0", 4'd1, 4'd9, 1'b1, 1'b0, 2'd0, 4'b1110, 8'h80, 1'b0);
    run_vec("sub19_s1", 4'd1, 4'd9, 1'b1, 1'b0, 2'd1, 4'b1101, 8'hC0, 1'b0);
    run_vec("sub19_s3", 4'd1, 4'd9, 1'b1, 1'b0, 2'd3, 4'b0111, 8'hBF, 1'b0);
    // Boundaries: 15+15=30, 15+1=16, 0-0, 15-0, 0-15
    run_vec("add3015_s0", 4'd15, 4'd15, 1'b0, 1'b0, 2'd0, 4'b1110, 8'hC0, 1'b1);
    run_vec("add3015_s1", 4'd15, 4'd15, 1'b0, 1'b0, 2'd1, 4'b1101, 8'hB0, 1'b1);
    run_vec("add16_s0",  4'd15, 4'd1,  1'b0, 1'b0, 2'd0, 4'b1110, 8'h82, 1'b1);
    run_vec("add16_s1",  4'd15, 4'd1,  1'b0, 1'b0, 2'd1, 4'b1101, 8'hF9, 1'b1);
    run_vec("add25_s1",  4'd12, 4'd13, 1'b0, 1'b0, 2'd1, 4'b1101, 8'hA4, 1'b1);
    run_vec("add25_s0",  4'd12, 4'd13, 1'b0, 1'b0, 2'd0, 4'b1110, 8'h92, 1'b1);
    run_vec("sub00_s0",  4'd0,  4'd0,  1'b1, 1'b0, 2'd0, 4'b1110, 8'hC0, 1'b1);
    run_vec("sub00_s3",  4'd0,  4'd0,  1'b1, 1'b0, 2'd3, 4'b0111, 8'hFF, 1'b1);
    run_vec("sub150_s0", 4'd15, 4'd0,  1'b1, 1'b0, 2'd0, 4'b1110, 8'h92, 1'b1);
    run_vec("sub150_s1", 4'd15, 4'd0,  1'b1, 1'b0, 2'd1, 4'b1101, 8'hF9, 1'b1);
    run_vec("sub015_s0", 4'd0,  4'd15, 1'b1, 1'b0, 2'd0, 4'b1110, 8'h92, 1'b0);
    run_vec("sub015_s3", 4'd0,  4'd15, 1'b1, 1'b0, 2'd3, 4'b0111, 8'hBF, 1'b0);
    run_vec("sub74_s0",  4'd7,  4'd4,  1'b1, 1'b0, 2'd0, 4'b1110, 8'hB0, 1'b1);
    run_vec("add34_s0",  4'd3,  4'd4,  1'b0, 1'b0, 2'd0, 4'b1110, 8'hF8, 1'b0);
    run_vec("add22_s0",  4'd2,  4'd2,  1'b0, 1'b0, 2'd0, 4'b1110, 8'h99, 1'b0);
    run_vec("add45_s0",  4'd4,  4'd5,  1'b0, 1'b0, 2'd0, 4'b1110, 8'h90, 1'b0);

    // Disabled display still reports carry; re-enable restores next edge
    run_vec("en_off",  4'd9, 4'd9, 1'b0, 1'b1, 2'd0, 4'b1111, 8'hFF, 1'b1);
    run_vec("en_back", 4'd9, 4'd9, 1'b0, 1'b0, 2'd0, 4'b1110, 8'h80, 1'b1);

    // Inputs change between edges: outputs must hold until the next edge
    i_a           = 4'd8;
    i_b           = 4'd2;
    i_mode        = 1'b1;
    i_digitSelect = 2'd1;
    #2;
    check_val("latency_hold_font",  {8'd0, o_font},   16'h0080);
    check_val("latency_hold_digit", {12'd0, o_digit}, 16'h000E);
    @(posedge i_clk);
    #1;
    check_val("latency_new_font",  {8'd0, o_font},   16'h00C0);
    check_val("latency_new_digit", {12'd0, o_digit}, 16'h000D);

    // Asynchronous reset between edges
    #2;
    i_reset = 1'b1;
    #1;
    check_val("midrst_digit", {12'd0, o_digit}, 16'h000F);
    check_val("midrst_font",  {8'd0, o_font},   16'h00FF);
    check_val("midrst_c",     {15'd0, o_c},     16'h0000);
    @(posedge i_clk);
    #2;
    i_reset = 1'b0;
    check_val("midrst_hold_font", {8'd0, o_font}, 16'h00FF);
    @(posedge i_clk);
    #1;
    check_val("post_rst_digit", {12'd0, o_digit}, 16'h000D);
    check_val("post_rst_font",  {8'd0, o_font},   16'h00C0);
    check_val("post_rst_c",     {15'd0, o_c},     16'h0001);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/add_sub_4bit_bcd_to_fnd.md
ADD_SUB_4BIT_BCD_TO_FND -- requirements
Module: add_sub_4bit_bcd_to_fnd

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single system clock, rising-edge active.
REQ-002 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port i_digitSelect, input, 2 bits: index of the FND digit to drive (0..3).
REQ-004 SHALL have port i_en, input, 1 bit: active-low display enable; 1 blanks the display.
REQ-005 SHALL have port i_mode, input, 1 bit: operation select; 0 = add, 1 = subtract.
REQ-006 SHALL have port i_a, input, 4 bits: unsigned operand A (0..15).
REQ-007 SHALL have port i_b, input, 4 bits: unsigned operand B (0..15).
REQ-008 SHALL have port o_digit, output, 4 bits: active-low one-hot digit common select.
REQ-009 SHALL have port o_font, output, 8 bits: active-low segment pattern, bit order {dp,g,f,e,d,c,b,a}.
REQ-010 SHALL have port o_c, output, 1 bit: carry out of the 4-bit add/subtract.

Function
REQ-011 SHALL sample i_a, i_b, i_mode, i_en and i_digitSelect on every rising i_clk edge; o_digit, o_font and o_c SHALL be registered, giving exactly 1-cycle latency from inputs to outputs.
REQ-012 Add (i_mode=0): SHALL compute the 5-bit value {c,s} = i_a + i_b (range 0..30); o_c = bit 4.
REQ-013 Subtract (i_mode=1): SHALL compute {c,s} = i_a + ~i_b + 1 in 4 bits; o_c = carry out (1 when i_a >= i_b, 0 on borrow).
REQ-014 Displayed value: add → decimal value of {c,s}; subtract → magnitude |i_a - i_b| (0..15), plus a negative flag set when i_a < i_b.
REQ-015 Digit contents: digit0 = units of the displayed value; digit1 = tens (0..3); digit2 = blank; digit3 = minus sign when the negative flag is set, otherwise blank.
REQ-016 Leading zero in digit1 SHALL be shown as '0' (no leading-zero suppression).
REQ-017 o_digit SHALL be 4'b1110, 4'b1101, 4'b1011 or 4'b0111 for i_digitSelect 0, 1, 2, 3 respectively.
REQ-018 Font codes SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF, minus=BF (hex).
REQ-019 When i_en=1: o_digit SHALL be 4'b1111 and o_font SHALL be 8'hFF; o_c SHALL still reflect the arithmetic result.
REQ-020 Operand changes and i_digitSelect changes SHALL take effect on the same clock edge, with no glitch state visible on the outputs.
REQ-021 Decimal split SHALL use combinational logic only (no iterative or multi-cycle conversion).

Reset
REQ-022 While i_reset=1, asynchronously: o_digit = 4'b1111, o_font = 8'hFF, o_c = 0.
REQ-023 After i_reset deasserts, the first rising edge SHALL load outputs from the current inputs.
REQ-024 Reset asserted mid-operation SHALL override all outputs immediately, regardless of the clock.

Verification
REQ-025 Add, a=3, b=7, i_en=0: sel=0 → o_digit=1110, o_font=C0; sel=1 → o_digit=1101, o_font=F9; o_c=0.
REQ-026 Add, a=9, b=9: o_c=1; sel=0 → 80 ('8'); sel=1 → F9 ('1'); sel=2 and sel=3 → FF.
REQ-027 Subtract, a=8, b=2: o_c=1; sel=0 → 82 ('6'); sel=1 → C0; sel=3 → FF.
REQ-028 Subtract, a=1, b=9: o_c=0; sel=0 → 80 ('8'); sel=3 → o_digit=0111, o_font=BF.
REQ-029 i_en=1 with any operands: o_digit=1111, o_font=FF one cycle later; returning i_en to 0 restores the digit on the next edge.
REQ-030 Assert i_reset between clock edges during activity: outputs go to 1111 / FF / 0 without waiting for a clock edge; normal output resumes on the first edge after release.
